hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Sequences stalls, bubbles and flushes for the 5-stage pipeline alongside the forwarding unit.
//  Detects cases that forwarding cannot cover:
//   - load-use hazards;
//   - ID-stage branch-compare dependencies on an EX result or a MEM load.
//  Holds PC and IF/ID for the required number of cycles and inserts ID/EX bubbles.
//  Also handles the external memory stall and taken-branch flush.
// PARAMETERS
//  AddressSize   5    register address width
//  PerfCntW      32   width of optional performance counters
// PORTS
//  clk            in   1            single clock, rising edge
//  arst           in   1            asynchronous, active-high reset
//  id_rs1         in   AddressSize  rs1 of instruction in ID
//  id_rs2         in   AddressSize  rs2 of instruction in ID
//  id_use_rs1     in   1            ID instruction reads rs1
//  id_use_rs2     in   1            ID instruction reads rs2
//  id_is_branch   in   1            ID instruction is a conditional branch (compare in ID)
//  branch_taken   in   1            ID compare resolved taken this cycle
//  ex_rd          in   AddressSize  destination of instruction in EX
//  ex_reg_write   in   1            EX instruction writes a register
//  ex_mem_read    in   1            EX instruction is a load
//  mem_rd         in   AddressSize  destination of instruction in MEM
//  mem_mem_read   in   1            MEM instruction is a load
//  ext_stall      in   1            data memory not ready; freeze whole pipeline
//  pc_write_en    out  1            PC may update
//  ifid_write_en  out  1            IF/ID register may update
//  idex_bubble    out  1            load NOP into ID/EX
//  ifid_flush     out  1            clear IF/ID (squash fetched instruction)
//  stall_cycles   out  PerfCntW     hazard stall cycle count (macro only)
//  flush_count    out  PerfCntW     taken-branch flush count (macro only)
// BEHAVIOUR
//  Match rule (mX):
//   - X != 0
//   - X == id_rs1 && id_use_rs1, or X == id_rs2 && id_use_rs2
//  Bubbles required (need), evaluated in RUN only:
//   - ex_mem_read && ex_reg_write && m(ex_rd) && id_is_branch        -> 2
//   - else ex_mem_read && ex_reg_write && m(ex_rd)                   -> 1
//   - else id_is_branch && ex_reg_write && m(ex_rd)                  -> 1
//   - else id_is_branch && mem_mem_read && m(mem_rd)                 -> 1
//   - else 0
//  FSM {RUN, STALL}; 2-bit counter cnt.
//  Outputs are combinational from state and inputs, so a stall takes effect in the detecting cycle.
//  Priority: ext_stall > hazard stall > flush.
//  ext_stall=1, any state:
//   - pc_write_en=0, ifid_write_en=0, idex_bubble=0, ifid_flush=0
//   - state, cnt and counters frozen
//  RUN, need=0:
//   - pc_write_en=1, ifid_write_en=1, idex_bubble=0
//   - ifid_flush=branch_taken
//  RUN, need>0:
//   - pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0
//   - cnt<=need-1; next=STALL if need==2, else RUN
//  STALL:
//   - outputs same as a stalled RUN cycle
//   - cnt<=cnt-1; when cnt==1, next=RUN
//   - hazard inputs ignored
//  On the first RUN cycle after STALL, hazards re-evaluate; a residual match may stall again.
//  branch_taken is ignored while stalling (compare operands not yet valid).
//  Reset (arst=1, asynchronous):
//   - state=RUN, cnt=0, counters=0
//   - outputs forced: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0
//  Deassertion mid-stall: restarts in RUN with no pending bubbles.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - stall_cycles increments on each cycle with idex_bubble=1 and ext_stall=0, outside reset
//   - flush_count increments on each cycle with ifid_flush=1
//   - both counters wrap at 2^PerfCntW
//  HAZARD_PERF_CNT_EN undefined: both ports tied to 0; no counter flops.
// TESTING
//  1. ALU use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_use_rs1=1, id_is_branch=0
//     -> exactly 1 cycle with pc_write_en=0, idex_bubble=1; back in RUN.
//  2. Branch after load: same as 1 with id_is_branch=1
//     -> 2 consecutive stall cycles; state RUN after the second.
//  3. Branch on ALU result: ex_reg_write=1, ex_mem_read=0, ex_rd=7, id_rs2=7, id_use_rs2=1,
//     id_is_branch=1 -> 1 bubble; same with ex_rd=0 -> no stall.
//  4. ext_stall=1 during STALL cycle 1 of case 2 for 3 cycles
//     -> all enables 0, idex_bubble=0; 1 stall cycle remains after release.
//  5. branch_taken=1 in RUN, need=0 -> ifid_flush=1 for one cycle;
//     branch_taken=1 while need>0 -> ifid_flush=0.
//  6. arst asserted mid-STALL -> outputs at reset values immediately;
//     after release, RUN, and with HAZARD_PERF_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus: pipeline-side hazard information in, pipeline control out.
// The master modport is the pipeline side; the slave modport is the controller side.
// stall_cycles/flush_count carry data only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_controller_if #(
    parameter int unsigned AddressSize = 5,
    parameter int unsigned PerfCntW    = 32
) ();
    logic [AddressSize-1:0] id_rs1;
    logic [AddressSize-1:0] id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic                   id_is_branch;
    logic                   branch_taken;
    logic [AddressSize-1:0] ex_rd;
    logic                   ex_reg_write;
    logic                   ex_mem_read;
    logic [AddressSize-1:0] mem_rd;
    logic                   mem_mem_read;
    logic                   ext_stall;
    logic                   pc_write_en;
    logic                   ifid_write_en;
    logic                   idex_bubble;
    logic                   ifid_flush;
    logic [PerfCntW-1:0]    stall_cycles;
    logic [PerfCntW-1:0]    flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, branch_taken,
        output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read, ext_stall,
        input  pc_write_en, ifid_write_en, idex_bubble, ifid_flush, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, branch_taken,
        input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read, ext_stall,
        output pc_write_en, ifid_write_en, idex_bubble, ifid_flush, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard stall controller for the 5-stage pipeline.
// Detects load-use and ID-branch-compare hazards that forwarding cannot resolve, holds PC and
// IF/ID while inserting ID/EX bubbles, freezes on external memory stall and squashes IF/ID on
// a taken branch. Outputs are combinational so a stall acts in the cycle it is detected.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller #(
    parameter int unsigned AddressSize = 5,
    parameter int unsigned PerfCntW    = 32
) (
    input  logic                       clk,
    input  logic                       arst,
    hazard_stall_controller_if.slave   bus
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;

    logic       w_ex_match;
    logic       w_mem_match;
    logic [1:0] w_need;

    logic       w_pc_write_en;
    logic       w_ifid_write_en;
    logic       w_idex_bubble;
    logic       w_ifid_flush;

    logic [AddressSize-1:0] w_ex_rd;
    logic [AddressSize-1:0] w_mem_rd;

    assign w_ex_rd  = bus.ex_rd;
    assign w_mem_rd = bus.mem_rd;

    // Register x0 never carries a dependency.
    always_comb begin
        w_ex_match  = (w_ex_rd != '0) &&
                      ((w_ex_rd == bus.id_rs1 && bus.id_use_rs1) ||
                       (w_ex_rd == bus.id_rs2 && bus.id_use_rs2));
        w_mem_match = (w_mem_rd != '0) &&
                      ((w_mem_rd == bus.id_rs1 && bus.id_use_rs1) ||
                       (w_mem_rd == bus.id_rs2 && bus.id_use_rs2));
    end

    // Number of bubbles the ID instruction needs; a branch on a load needs two.
    always_comb begin
        w_need = 2'd0;
        if (bus.ex_mem_read && bus.ex_reg_write && w_ex_match && bus.id_is_branch) begin
            w_need = 2'd2;
        end else if (bus.ex_mem_read && bus.ex_reg_write && w_ex_match) begin
            w_need = 2'd1;
        end else if (bus.id_is_branch && bus.ex_reg_write && w_ex_match) begin
            w_need = 2'd1;
        end else if (bus.id_is_branch && bus.mem_mem_read && w_mem_match) begin
            w_need = 2'd1;
        end
    end

    // Next-state and control outputs; ext_stall overrides hazards, hazards override flush.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_pc_write_en   = 1'b1;
        w_ifid_write_en = 1'b1;
        w_idex_bubble   = 1'b0;
        w_ifid_flush    = 1'b0;

        if (arst) begin
            w_pc_write_en   = 1'b0;
            w_ifid_write_en = 1'b0;
            w_idex_bubble   = 1'b1;
        end else if (bus.ext_stall) begin
            w_pc_write_en   = 1'b0;
            w_ifid_write_en = 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_need != 2'd0) begin
                        w_pc_write_en   = 1'b0;
                        w_ifid_write_en = 1'b0;
                        w_idex_bubble   = 1'b1;
                        w_cnt_next      = w_need - 2'd1;
                        w_state_next    = (w_need == 2'd2) ? StStall : StRun;
                    end else begin
                        w_ifid_flush = bus.branch_taken;
                    end
                end
                StStall: begin
                    // Hazard inputs and branch_taken are not looked at here.
                    w_pc_write_en   = 1'b0;
                    w_ifid_write_en = 1'b0;
                    w_idex_bubble   = 1'b1;
                    w_cnt_next      = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        w_state_next = StRun;
                    end
                end
                default: begin
                    w_state_next = StRun;
                    w_cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // State and remaining-bubble counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= StRun;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign bus.pc_write_en   = w_pc_write_en;
    assign bus.ifid_write_en = w_ifid_write_en;
    assign bus.idex_bubble   = w_idex_bubble;
    assign bus.ifid_flush    = w_ifid_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [PerfCntW-1:0] r_stall_cycles;
    logic [PerfCntW-1:0] r_flush_count;

    // Performance counters; wrap naturally, frozen by ext_stall.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_idex_bubble && !bus.ext_stall) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_ifid_flush) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`else
    assign bus.stall_cycles = {PerfCntW{1'b0}};
    assign bus.flush_count  = {PerfCntW{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed cases plus randomized stimulus
// against a behavioural model that tracks "stall cycles still owed" and applies the bubble rules.
module tb_hazard_stall_controller;

    localparam int unsigned AddressSize = 5;
    localparam int unsigned PerfCntW    = 32;

    logic clk;
    logic arst;

    hazard_stall_controller_if #(.AddressSize(AddressSize), .PerfCntW(PerfCntW)) u_if ();

    hazard_stall_controller #(.AddressSize(AddressSize), .PerfCntW(PerfCntW)) u_dut (
        .clk  (clk),
        .arst (arst),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model state: stall cycles still owed, and counters.
    int          m_pend;
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic reads(input logic [4:0] x);
        return x != 5'd0 &&
               ((x == u_if.id_rs1 && u_if.id_use_rs1) || (x == u_if.id_rs2 && u_if.id_use_rs2));
    endfunction

    function automatic int model_need();
        logic ld_dep;
        ld_dep = u_if.ex_mem_read && u_if.ex_reg_write && reads(u_if.ex_rd);
        if (ld_dep) return u_if.id_is_branch ? 2 : 1;
        if (u_if.id_is_branch && u_if.ex_reg_write && reads(u_if.ex_rd)) return 1;
        if (u_if.id_is_branch && u_if.mem_mem_read && reads(u_if.mem_rd)) return 1;
        return 0;
    endfunction

    task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, ".stall_cycles"}, u_if.stall_cycles, m_sc);
        check_eq({tag, ".flush_count"}, u_if.flush_count, m_fc);
`else
        check_eq({tag, ".stall_cycles"}, u_if.stall_cycles, 32'd0);
        check_eq({tag, ".flush_count"}, u_if.flush_count, 32'd0);
`endif
    endtask

    // One clock cycle: drive at negedge, check before posedge, then advance the model.
    task automatic step(input string tag,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic br, input logic bt,
                        input logic [4:0] exrd, input logic exrw, input logic exmr,
                        input logic [4:0] memrd, input logic memmr, input logic ext);
        logic e_pc, e_bub, e_fl;
        int   nxt;
        @(negedge clk);
        u_if.id_rs1 = rs1;        u_if.id_rs2 = rs2;
        u_if.id_use_rs1 = u1;     u_if.id_use_rs2 = u2;
        u_if.id_is_branch = br;   u_if.branch_taken = bt;
        u_if.ex_rd = exrd;        u_if.ex_reg_write = exrw;  u_if.ex_mem_read = exmr;
        u_if.mem_rd = memrd;      u_if.mem_mem_read = memmr; u_if.ext_stall = ext;
        #1;
        nxt = m_pend;
        if (ext) begin
            e_pc = 1'b0; e_bub = 1'b0; e_fl = 1'b0;
        end else if (m_pend > 0) begin
            e_pc = 1'b0; e_bub = 1'b1; e_fl = 1'b0;
            nxt = m_pend - 1;
        end else if (model_need() > 0) begin
            e_pc = 1'b0; e_bub = 1'b1; e_fl = 1'b0;
            nxt = model_need() - 1;
        end else begin
            e_pc = 1'b1; e_bub = 1'b0; e_fl = bt;
        end
        check_eq({tag, ".pc_write_en"}, {31'd0, u_if.pc_write_en}, {31'd0, e_pc});
        check_eq({tag, ".ifid_write_en"}, {31'd0, u_if.ifid_write_en}, {31'd0, e_pc});
        check_eq({tag, ".idex_bubble"}, {31'd0, u_if.idex_bubble}, {31'd0, e_bub});
        check_eq({tag, ".ifid_flush"}, {31'd0, u_if.ifid_flush}, {31'd0, e_fl});
        check_counters(tag);
        @(posedge clk);
        m_pend = nxt;
        if (e_bub && !ext) m_sc = m_sc + 32'd1;
        if (e_fl) m_fc = m_fc + 32'd1;
    endtask

    task automatic idle(input string tag);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle, check forced outputs immediately, release with quiet inputs.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        m_pend = 0; m_sc = 32'd0; m_fc = 32'd0;
        check_eq({tag, ".pc_write_en"}, {31'd0, u_if.pc_write_en}, 32'd0);
        check_eq({tag, ".ifid_write_en"}, {31'd0, u_if.ifid_write_en}, 32'd0);
        check_eq({tag, ".idex_bubble"}, {31'd0, u_if.idex_bubble}, 32'd1);
        check_eq({tag, ".ifid_flush"}, {31'd0, u_if.ifid_flush}, 32'd0);
        check_counters(tag);
        u_if.id_use_rs1 = 1'b0; u_if.id_use_rs2 = 1'b0; u_if.id_is_branch = 1'b0;
        u_if.branch_taken = 1'b0; u_if.ex_reg_write = 1'b0; u_if.ex_mem_read = 1'b0;
        u_if.mem_mem_read = 1'b0; u_if.ext_stall = 1'b0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_pend = 0; m_sc = 32'd0; m_fc = 32'd0;
        arst = 1'b0;
        u_if.id_rs1 = '0; u_if.id_rs2 = '0; u_if.ex_rd = '0; u_if.mem_rd = '0;
        do_reset("reset");

        // Load-use on ALU instruction: one bubble.
        step("alu_use", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        idle("alu_use_after");
        // Branch after load: two bubbles, taken branch ignored while stalled.
        step("br_ld0", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        step("br_ld1", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        idle("br_ld_after");
        // Branch on ALU result, then same with rd=x0.
        step("br_alu", 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step("br_x0", 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        // Branch on a load sitting in MEM.
        step("br_mem", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        // ext_stall in the STALL cycle of a branch-after-load for 3 cycles.
        step("ext0", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("ext_hold", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0,
                 1'b1);
        end
        step("ext_rel", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        idle("ext_after");
        // Taken branch with and without a hazard.
        step("flush", 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step("no_flush", 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        // Reset in the middle of a two-cycle stall.
        step("rst_st", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        do_reset("rst_mid");
        idle("rst_after");

        // Random traffic over a small register set so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd",
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                     5'($urandom_range(0, 3)), 1'($urandom),
                     1'($urandom_range(0, 5) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
